// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, main-control aluop values
// and the R-type funct field values that the ALU-control decode recognises.
package alu_exec_unit_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_NOR = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_AND = 4'b0100;
    localparam logic [3:0] FUNCT_OR  = 4'b0101;
    localparam logic [3:0] FUNCT_NOR = 4'b0111;
    localparam logic [3:0] FUNCT_SLT = 4'b1010;

endpackage

// File: rtl/alu_exec_unit_ctrl_decode.sv
// ALU-control decode: maps main-control aluop and the low funct bits to an ALU op code.
module alu_ctrl_decode
    import alu_exec_unit_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [3:0] funct,
    output logic [2:0] gout
);

    always_comb begin
        gout = ALU_ADD;
        case (aluop)
            ALUOP_MEM:   gout = ALU_ADD;
            ALUOP_BEQ:   gout = ALU_SUB;
            ALUOP_ORI:   gout = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: gout = ALU_ADD;
                    FUNCT_SUB: gout = ALU_SUB;
                    FUNCT_AND: gout = ALU_AND;
                    FUNCT_OR:  gout = ALU_OR;
                    FUNCT_NOR: gout = ALU_NOR;
                    FUNCT_SLT: gout = ALU_SLT;
                    default:   gout = ALU_ADD;
                endcase
            end
            default: gout = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic: decoded ALU with Z/N/V flags, free-standing adder,
// and a status register capturing the last ALU flags every cycle.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [2:0]       gout,
    output logic [WIDTH-1:0] alu_result,
    output logic             zout,
    output logic             nout,
    output logic             vout,
    output logic [WIDTH-1:0] add_sum,
    output logic             v_flag,
    output logic             z_flag,
    output logic             n_flag
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             v_add;
    logic             v_sub;
    logic             slt;

    alu_ctrl_decode u_decode (
        .aluop (aluop),
        .funct (funct),
        .gout  (gout)
    );

    assign sum   = alu_a + alu_b;
    assign diff  = alu_a - alu_b;
    assign v_add = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1]  != alu_a[WIDTH-1]);
    assign v_sub = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
    // Correcting the difference sign with overflow keeps slt right for extreme operands.
    assign slt   = diff[WIDTH-1] ^ v_sub;

    always_comb begin
        alu_result = '0;
        vout       = 1'b0;
        case (gout)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_NOR: alu_result = ~(alu_a | alu_b);
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt};
            ALU_ADD: begin
                alu_result = sum;
                vout       = v_add;
            end
            ALU_SUB: begin
                alu_result = diff;
                vout       = v_sub;
            end
            default: alu_result = '0;
        endcase
    end

    assign zout    = (alu_result == '0);
    assign nout    = alu_result[WIDTH-1];
    assign add_sum = add_a + add_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_flag <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else begin
            v_flag <= vout;
            z_flag <= zout;
            n_flag <= nout;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised self-checking bench for alu_exec_unit against a signed-arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] alu_a, alu_b, add_a, add_b;
    logic [2:0]  gout;
    logic [31:0] alu_result, add_sum;
    logic        zout, nout, vout, v_flag, z_flag, n_flag;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aluop      (aluop),
        .funct      (funct),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .gout       (gout),
        .alu_result (alu_result),
        .zout       (zout),
        .nout       (nout),
        .vout       (vout),
        .add_sum    (add_sum),
        .v_flag     (v_flag),
        .z_flag     (z_flag),
        .n_flag     (n_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: op selected from the decode table, arithmetic done in 64-bit signed space.
    task automatic model(input logic [1:0] op, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [2:0] g, output logic [31:0] r, output logic v);
        longint sa, sb, full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00)      g = 3'b010;
        else if (op == 2'b01) g = 3'b110;
        else if (op == 2'b11) g = 3'b001;
        else begin
            case (fn)
                4'd0:    g = 3'b010;
                4'd2:    g = 3'b110;
                4'd4:    g = 3'b000;
                4'd5:    g = 3'b001;
                4'd7:    g = 3'b100;
                4'd10:   g = 3'b111;
                default: g = 3'b010;
            endcase
        end
        v = 1'b0;
        full = 0;
        case (g)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b100: r = ~(a | b);
            3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
            3'b010, 3'b110: begin
                full = (g == 3'b010) ? sa + sb : sa - sb;
                r = full[31:0];
                v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            default: r = 32'd0;
        endcase
    endtask

    task automatic apply(input string tag, input logic [1:0] op, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] aa, input logic [31:0] ab);
        logic [2:0]  eg;
        logic [31:0] er;
        logic [63:0] es;
        logic        ev;
        @(negedge clk);
        aluop = op; funct = fn; alu_a = a; alu_b = b; add_a = aa; add_b = ab;
        model(op, fn, a, b, eg, er, ev);
        es = {32'd0, aa} + {32'd0, ab};
        #1;
        chk({tag, " gout"}, {29'd0, gout}, {29'd0, eg});
        chk({tag, " result"}, alu_result, er);
        chk({tag, " zvn"}, {29'd0, zout, vout, nout}, {29'd0, er == 32'd0, ev, er[31]});
        chk({tag, " add_sum"}, add_sum, es[31:0]);
        @(posedge clk);
        #1;
        chk({tag, " flags"}, {29'd0, z_flag, v_flag, n_flag}, {29'd0, er == 32'd0, ev, er[31]});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] fn_tab [6];
        logic [3:0] fn;
        logic [31:0] a;
        fn_tab = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd10};
        rst_n = 1'b0;
        aluop = 2'b00; funct = 4'd0;
        alu_a = 32'd0; alu_b = 32'd0; add_a = 32'd0; add_b = 32'd0;
        #12;
        chk("reset flags", {29'd0, z_flag, v_flag, n_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("add7+5",  2'b10, 4'd0,  32'd7, 32'd5, 32'd0, 32'd0);
        apply("beq eq",  2'b01, 4'd3,  32'h1234, 32'h1234, 32'd4, 32'd8);
        apply("add ovf", 2'b00, 4'd0,  32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        apply("slt min", 2'b10, 4'd10, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
        apply("slt 1,-1",2'b10, 4'd10, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
        apply("ori",     2'b11, 4'd9,  32'hF0, 32'h0F, 32'd0, 32'd0);
        apply("nor 0",   2'b10, 4'd7,  32'd0, 32'd0, 32'd0, 32'd0);
        apply("pc wrap", 2'b10, 4'd15, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'd4);
        apply("sub ovf", 2'b10, 4'd2,  32'h8000_0000, 32'd1, 32'd0, 32'd0);

        // Async reset mid-cycle while flags hold a nonzero value.
        apply("pre rst", 2'b00, 4'd0,  32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async", {29'd0, z_flag, v_flag, n_flag}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst hold", {29'd0, z_flag, v_flag, n_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst release", {29'd0, z_flag, v_flag, n_flag}, 32'd3);

        for (int i = 0; i < 400; i++) begin
            fn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : fn_tab[$urandom_range(0, 5)];
            a  = pick();
            apply("rand", 2'($urandom), fn, a, ($urandom_range(0, 5) == 0) ? a : pick(),
                  pick(), pick());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
